// File: rtl/branch_resolve_ctrl.sv
// Early branch resolution controller for the ID-stage equality comparator: hazard stalls,
// comparator operand forwarding and pc_src/if_flush. Optional stats counters: BRANCH_STATS_EN.
module branch_resolve_ctrl #(
    parameter int REG_W     = 5,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             cmp_equal,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_src,
    output logic             if_flush,
    output logic [1:0]       state_dbg
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);

    // state_dbg mirrors the encoding: 0 IDLE, 1 STALL, 2 RESOLVE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] need;
    logic             br, taken, resolve_now, stall_int;
    logic             ex_hit, mem_hit;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    assign br    = id_valid & (id_beq | id_bne);
    assign taken = id_beq ? cmp_equal : ~cmp_equal;

    assign ex_hit  = (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign mem_hit = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

    always_comb begin
        need = '0;
        if (ex_memread && ex_hit)
            need = CNT_W'(2);
        else if (ex_regwrite && ex_hit)
            need = CNT_W'(1);
        else if (mem_memread && mem_hit)
            need = CNT_W'(1);
    end

    // A load in MEM has no result on the EX/MEM ALU path yet, so it never forwards from there.
    assign fwd_a_raw = (mem_regwrite && !mem_memread && mem_rd == id_rs && id_rs != '0) ? 2'b01 :
                       (wb_regwrite && wb_rd == id_rs && id_rs != '0)                   ? 2'b10 : 2'b00;
    assign fwd_b_raw = (mem_regwrite && !mem_memread && mem_rd == id_rt && id_rt != '0) ? 2'b01 :
                       (wb_regwrite && wb_rd == id_rt && id_rt != '0)                   ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The IDLE cycle that detects the hazard is the first stall cycle; cnt then holds the
    // stall cycles still owed, so a one-cycle stall goes straight to RESOLVE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (br && need != '0) begin
                    cnt_nx   = need - CNT_W'(1);
                    state_nx = (need == CNT_W'(1)) ? RESOLVE : STALL;
                end
            end
            STALL: begin
                if (!id_valid) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    if (cnt != '0)
                        cnt_nx = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1))
                        state_nx = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        stall_int   = 1'b0;
        resolve_now = 1'b0;
        case (state)
            IDLE: begin
                if (br) begin
                    if (need != '0)
                        stall_int = 1'b1;
                    else
                        resolve_now = 1'b1;
                end
            end
            STALL:   stall_int   = id_valid;
            RESOLVE: resolve_now = br;
            default: begin
                stall_int   = 1'b0;
                resolve_now = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the live ID inputs.
    assign stall     = reset & stall_int;
    assign pc_src    = reset & resolve_now & taken;
    assign if_flush  = reset & resolve_now & taken;
    assign fwd_a_sel = reset ? fwd_a_raw : 2'b00;
    assign fwd_b_sel = reset ? fwd_b_raw : 2'b00;
    assign state_dbg = state;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_src && taken_cnt != 16'hFFFF)
                taken_cnt <= taken_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
